chunked_borrow_subtractor: RTL and testbench

- Multi-cycle W-bit subtractor computing D = A - B - Bin.
- Processes one n-bit digit per clock, least-significant first.
- Inside each digit, borrows are formed with generate/propagate lookahead terms; the digit's borrow-out is registered and carried into the next digit.
- Serves as the subtraction datapath next to the lookahead adder wherever wide operands must meet timing at the cost of latency.

---
 rtl/chunked_borrow_subtractor.sv | 167 ++++++++++++++++
 tb/tb_chunked_borrow_subtractor.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_borrow_subtractor.sv
// chunked_borrow_subtractor
// Multi-cycle W-bit subtractor, D = A - B - Bin. One n-bit digit is handled
// per clock, least-significant digit first. Within a digit the borrows come
// from a flat generate/propagate lookahead. The digit borrow-out is
// registered and fed into the next digit.
module chunked_borrow_subtractor #(
    parameter int W = 16,
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Bin,
    output logic [W-1:0] D,
    output logic         Bout,
    output logic         V,
    output logic         done
);

    // Number of digits per operand, and an index width that stays legal when W == n.
    localparam int ND = W / n;
    localparam int IDXW = (ND > 1) ? $clog2(ND) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(ND - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    logic [IDXW-1:0] idx_r;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic            borrow_r;

    logic [n-1:0]    a_dig_s;
    logic [n-1:0]    b_dig_s;
    logic [n-1:0]    g_s;
    logic [n-1:0]    p_s;
    logic [n:0]      borrows_s;
    logic [n-1:0]    diff_s;
    logic            last_s;

    // Borrow into every bit position of a digit, each one written as a flat
    // sum of products of g, p and the digit borrow-in. No term depends on
    // another computed borrow, so the logic depth is independent of the
    // bit position.
    // Element [0] is the digit borrow-in. Element [n] is the digit borrow-out.
    function automatic logic [n:0] lookahead_borrows(
        input logic [n-1:0] g,
        input logic [n-1:0] p,
        input logic         b0
    );
        logic [n:0] bw;
        logic       term;
        bw    = '0;
        bw[0] = b0;
        for (int i = 0; i < n; i++) begin
            // The product that carries the incoming borrow across bits 0..i.
            term = b0;
            for (int k = 0; k <= i; k++) begin
                term = term & p[k];
            end
            bw[i+1] = term;
            // A borrow generated at bit j and propagated up through bit i.
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                bw[i+1] = bw[i+1] | term;
            end
        end
        return bw;
    endfunction

    // Select the current digit of the latched operands and form its difference and borrows.
    always_comb begin
        a_dig_s = '0;
        b_dig_s = '0;
        for (int k = 0; k < ND; k++) begin
            a_dig_s = a_dig_s | (a_r[k*n +: n] & {n{idx_r == IDXW'(k)}});
            b_dig_s = b_dig_s | (b_r[k*n +: n] & {n{idx_r == IDXW'(k)}});
        end
        g_s       = ~a_dig_s & b_dig_s;
        p_s       = ~(a_dig_s ^ b_dig_s);
        borrows_s = lookahead_borrows(g_s, p_s, borrow_r);
        diff_s    = a_dig_s ^ b_dig_s ^ borrows_s[n-1:0];
        last_s    = (idx_r == LAST_IDX);
    end

    // Control FSM, operand latches, the digit borrow register and the registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            idx_r    <= '0;
            a_r      <= '0;
            b_r      <= '0;
            borrow_r <= 1'b0;
            D        <= '0;
            Bout     <= 1'b0;
            V        <= 1'b0;
            done     <= 1'b0;
            ready    <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r      <= A;
                        b_r      <= B;
                        borrow_r <= Bin;
                        idx_r    <= '0;
                        state_r  <= CALC;
                        ready    <= 1'b0;
                    end else begin
                        ready <= 1'b1;
                    end
                end
                CALC: begin
                    for (int k = 0; k < ND; k++) begin
                        if (idx_r == IDXW'(k)) begin
                            D[k*n +: n] <= diff_s;
                        end
                    end
                    borrow_r <= borrows_s[n];
                    if (last_s) begin
                        // diff_s[n-1] is the new sign bit of D. It is written on this same edge.
                        Bout    <= borrows_s[n];
                        V       <= (a_r[W-1] ^ b_r[W-1]) & (a_r[W-1] ^ diff_s[n-1]);
                        done    <= 1'b1;
                        ready   <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        idx_r <= idx_r + 1'b1;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r      <= A;
                        b_r      <= B;
                        borrow_r <= Bin;
                        idx_r    <= '0;
                        state_r  <= CALC;
                        ready    <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                        ready   <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    idx_r    <= '0;
                    borrow_r <= 1'b0;
                    done     <= 1'b0;
                    ready    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_borrow_subtractor.sv
// Scoreboard bench for chunked_borrow_subtractor. It drives two instances:
// W=16/n=4 with directed and random traffic, and W=12/n=3 with random
// traffic. Expected results come from plain integer arithmetic.
`timescale 1ns/1ps
module tb_chunked_borrow_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 16-bit instance signals
    logic        rst, start, bin, ready, bout, v, done;
    logic [15:0] a, b, d;
    // 12-bit instance signals
    logic        rst12, start12, bin12, ready12, bout12, v12, done12;
    logic [11:0] a12, b12, d12;

    chunked_borrow_subtractor #(.W(16), .n(4)) dut16 (
        .clk(clk), .rst(rst), .start(start), .ready(ready),
        .A(a), .B(b), .Bin(bin), .D(d), .Bout(bout), .V(v), .done(done)
    );

    chunked_borrow_subtractor #(.W(12), .n(3)) dut12 (
        .clk(clk), .rst(rst12), .start(start12), .ready(ready12),
        .A(a12), .B(b12), .Bin(bin12), .D(d12), .Bout(bout12), .V(v12), .done(done12)
    );

    typedef struct {
        longint d;
        longint bo;
        longint v;
    } exp_t;

    exp_t q16[$];
    exp_t q12[$];
    int checks = 0;
    int fails = 0;
    int acc16 = 0, acc12 = 0, done16_cnt = 0, done12_cnt = 0;

    function automatic void check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: exact integer arithmetic, then reduced to w bits.
    function automatic exp_t model(input int w, input longint av, input longint bv, input longint binv);
        exp_t   e;
        longint m    = longint'(1) << w;
        longint full = av - bv - binv;
        longint sa   = (av >= m / 2) ? av - m : av;
        longint sb   = (bv >= m / 2) ? bv - m : bv;
        longint sd   = sa - sb - binv;
        e.d  = (full < 0) ? full + m : full;
        e.bo = (full < 0) ? 1 : 0;
        e.v  = (sd < -(m / 2) || sd >= (m / 2)) ? 1 : 0;
        return e;
    endfunction

    // Monitor, 16-bit instance.
    always @(negedge clk) begin : mon16
        exp_t e;
        if (done) begin
            check("done16_has_pending", (q16.size() > 0), 1);
            if (q16.size() > 0) begin
                e = q16.pop_front();
                done16_cnt++;
                check("d16", d, e.d);
                check("bout16", bout, e.bo);
                check("v16", v, e.v);
            end
        end
    end

    // Monitor, 12-bit instance.
    always @(negedge clk) begin : mon12
        exp_t e;
        if (done12) begin
            check("done12_has_pending", (q12.size() > 0), 1);
            if (q12.size() > 0) begin
                e = q12.pop_front();
                done12_cnt++;
                check("d12", d12, e.d);
                check("bout12", bout12, e.bo);
                check("v12", v12, e.v);
            end
        end
    end

    // Watchdog
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic issue16(input logic [15:0] av, input logic [15:0] bv, input logic binv, input bit timed);
        int waitc = 0;
        @(negedge clk);
        while (!ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check("ready16_wait", ready, 1);
        if (ready) begin
            a = av; b = bv; bin = binv; start = 1'b1;
            q16.push_back(model(16, av, bv, binv));
            acc16++;
            @(negedge clk);
            start = 1'b0;
            a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
            if (timed) begin
                for (int i = 0; i < 4; i++) begin
                    check("ready16_low_in_calc", ready, 0);
                    check("done16_low_in_calc", done, 0);
                    @(negedge clk);
                end
                check("done16_latency", done, 1);
                check("ready16_in_done", ready, 1);
            end
        end
    endtask

    task automatic issue12(input logic [11:0] av, input logic [11:0] bv, input logic binv);
        int waitc = 0;
        @(negedge clk);
        while (!ready12 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check("ready12_wait", ready12, 1);
        if (ready12) begin
            a12 = av; b12 = bv; bin12 = binv; start12 = 1'b1;
            q12.push_back(model(12, av, bv, binv));
            acc12++;
            @(negedge clk);
            start12 = 1'b0;
            a12 = 12'($urandom); b12 = 12'($urandom); bin12 = 1'($urandom);
        end
    endtask

    task automatic wait_drain();
        int waitc = 0;
        while ((q16.size() > 0 || q12.size() > 0) && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        check("drain_q16_empty", q16.size(), 0);
        check("drain_q12_empty", q12.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [15:0] rnd_op16();
        int sel = $urandom_range(0, 9);
        if (sel == 0) return 16'h0000;
        if (sel == 1) return 16'hFFFF;
        if (sel == 2) return 16'h8000;
        if (sel == 3) return 16'h7FFF;
        return 16'($urandom);
    endfunction

    function automatic logic [11:0] rnd_op12();
        int sel = $urandom_range(0, 9);
        if (sel == 0) return 12'h000;
        if (sel == 1) return 12'hFFF;
        if (sel == 2) return 12'h800;
        if (sel == 3) return 12'h7FF;
        return 12'($urandom);
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        rst12 = 1'b1; start12 = 1'b0; a12 = '0; b12 = '0; bin12 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0; rst12 = 1'b0;

        // Reset state
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_d", d, 0);
        check("rst_bout", bout, 0);
        check("rst_v", v, 0);
        check("rst_ready12", ready12, 1);
        check("rst_d12", d12, 0);

        // Directed cases
        issue16(16'h1234, 16'h0235, 1'b0, 1'b1);
        issue16(16'h1000, 16'h0001, 1'b0, 1'b1);
        issue16(16'h0000, 16'h0001, 1'b0, 1'b1);
        issue16(16'h0005, 16'h0005, 1'b1, 1'b1);
        issue16(16'h8000, 16'h0001, 1'b0, 1'b1);
        issue16(16'h7FFF, 16'hFFFF, 1'b0, 1'b1);
        wait_drain();

        // Start held high with operands changing every cycle
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            check("hold_ready", ready, (c % 5 == 0));
            check("hold_done", done, ((c % 5 == 0) && (c > 0)));
            a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
            start = 1'b1;
            if (c % 5 == 0) begin
                q16.push_back(model(16, a, b, bin));
                acc16++;
            end
        end
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        // Reset in the middle of CALC, while idx is 2
        a = 16'h1357; b = 16'h2468; bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", ready, 1);
        check("midrst_done", done, 0);
        check("midrst_d", d, 0);
        check("midrst_bout", bout, 0);
        check("midrst_v", v, 0);
        issue16(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        wait_drain();

        // Random traffic on both instances
        fork
            begin
                for (int i = 0; i < 4000; i++) begin
                    issue16(rnd_op16(), rnd_op16(), 1'($urandom), 1'b0);
                    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
                end
            end
            begin
                for (int i = 0; i < 4000; i++) begin
                    issue12(rnd_op12(), rnd_op12(), 1'($urandom));
                    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
                end
            end
        join
        wait_drain();
        check("done16_count", done16_cnt, acc16);
        check("done12_count", done12_cnt, acc12);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
